// File: rtl/pulse_seq_pkg.sv
// Shared defaults, FSM state encoding and channel index width for the pulse sequencer.
package pulse_seq_pkg;

   localparam int N_CH_DEF = 20;
   localparam int CW_DEF   = 32;
   localparam int PW_DEF   = 16;
   localparam int CH_W     = 5;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_IDLE,
      ST_ARM,
      ST_RUN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/pulse_seq_bank.sv
// Double-buffered pulse tables: the shadow copy is written by configuration,
// the active copy feeds the io loop and is refreshed from shadow on swap_i.
module pulse_seq_bank
   import pulse_seq_pkg::*;
#(
   parameter int N_CH = N_CH_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we_i,
   input  logic [CH_W-1:0]         cfg_ch_i,
   input  logic [CW-1:0]           cfg_beg_i,
   input  logic [CW-1:0]           cfg_end_i,
   input  logic                    cfg_max_we_i,
   input  logic [CW-1:0]           cfg_max_i,
   input  logic                    swap_i,
   output logic [N_CH-1:0][CW-1:0] act_beg_o,
   output logic [N_CH-1:0][CW-1:0] act_end_o,
   output logic [CW-1:0]           act_max_o
);

   logic [CW-1:0] sh_max_q;
   logic [CW-1:0] act_max_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_max_q  <= '0;
         act_max_q <= '0;
      end else begin
         if (cfg_max_we_i) sh_max_q <= cfg_max_i;
         if (swap_i)       act_max_q <= sh_max_q;
      end
   end

   assign act_max_o = act_max_q;

   // Swap reads the pre-write shadow value, so a same-cycle write lands only in shadow.
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         logic          we;
         logic [CW-1:0] sh_beg_q;
         logic [CW-1:0] sh_end_q;
         logic [CW-1:0] act_beg_q;
         logic [CW-1:0] act_end_q;

         assign we = cfg_we_i && (cfg_ch_i == CH_W'(gi));

         always_ff @(posedge clk) begin
            if (rst) begin
               sh_beg_q  <= '0;
               sh_end_q  <= '0;
               act_beg_q <= '0;
               act_end_q <= '0;
            end else begin
               if (we) begin
                  sh_beg_q <= cfg_beg_i;
                  sh_end_q <= cfg_end_i;
               end
               if (swap_i) begin
                  act_beg_q <= sh_beg_q;
                  act_end_q <= sh_end_q;
               end
            end
         end

         assign act_beg_o[gi] = act_beg_q;
         assign act_end_o[gi] = act_end_q;
      end
   endgenerate

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse sequencer control FSM (OFF/IDLE/ARM/RUN/DONE) with period counting and
// wrap-aligned table swaps. Define PULSE_SEQ_SOFT_STOP_EN to let stop finish the current period.
module pulse_seq_ctrl
   import pulse_seq_pkg::*;
#(
   parameter int N_CH = N_CH_DEF,
   parameter int CW   = CW_DEF,
   parameter int PW   = PW_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic [CH_W-1:0]         cfg_ch,
   input  logic [CW-1:0]           cfg_beg,
   input  logic [CW-1:0]           cfg_end,
   input  logic                    cfg_max_we,
   input  logic [CW-1:0]           cfg_max,
   input  logic                    commit,
   input  logic                    start,
   input  logic                    stop,
   input  logic [PW-1:0]           n_periods,
   output logic [N_CH-1:0][CW-1:0] act_beg,
   output logic [N_CH-1:0][CW-1:0] act_end,
   output logic [CW-1:0]           act_max,
   output logic                    loop_en,
   output logic                    loop_go,
   output logic [CW-1:0]           count,
   output logic                    period_strb,
   output logic [PW-1:0]           periods_done,
   output logic                    swap_pend,
   output logic                    busy,
   output logic                    done
);

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] pd_q, pd_d;
   logic          pend_q, pend_d;
   logic          loop_en_q, loop_go_q, busy_q, done_q;
   logic          running, wrap, last, swap;
   logic [PW-1:0] pd_inc;
   logic [PW:0]   pd_plus1;
`ifdef PULSE_SEQ_SOFT_STOP_EN
   logic          stop_pend_q, stop_pend_d;
`endif

   pulse_seq_bank #(
      .N_CH (N_CH),
      .CW   (CW)
   ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .cfg_we_i     (cfg_we),
      .cfg_ch_i     (cfg_ch),
      .cfg_beg_i    (cfg_beg),
      .cfg_end_i    (cfg_end),
      .cfg_max_we_i (cfg_max_we),
      .cfg_max_i    (cfg_max),
      .swap_i       (swap),
      .act_beg_o    (act_beg),
      .act_end_o    (act_end),
      .act_max_o    (act_max)
   );

   assign running  = (state_q == ST_ARM) || (state_q == ST_RUN);
   assign wrap     = (state_q == ST_RUN) && (count_q == act_max);
   assign pd_plus1 = {1'b0, pd_q} + (PW+1)'(1);
   assign pd_inc   = (&pd_q) ? pd_q : pd_q + PW'(1);
   assign last     = (n_periods != '0) && (pd_plus1 == {1'b0, n_periods});

   // While the loop runs, a commit is deferred so the new table starts exactly at count 0.
   assign swap   = running ? (wrap && (pend_q || commit)) : (pend_q || commit);
   assign pend_d = swap ? 1'b0 : ((running && commit) ? 1'b1 : pend_q);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pd_d    = pd_q;
`ifdef PULSE_SEQ_SOFT_STOP_EN
      stop_pend_d = stop_pend_q;
`endif
      unique case (state_q)
         ST_OFF: state_d = ST_IDLE;
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_ARM;
               pd_d    = '0;
            end
         end
         ST_ARM: begin
            count_d = '0;
            state_d = stop ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
`ifdef PULSE_SEQ_SOFT_STOP_EN
            if (wrap) begin
               count_d     = '0;
               pd_d        = pd_inc;
               stop_pend_d = 1'b0;
               if (stop_pend_q || stop) state_d = ST_IDLE;
               else if (last)           state_d = ST_DONE;
            end else begin
               count_d = count_q + CW'(1);
               if (stop) stop_pend_d = 1'b1;
            end
`else
            if (stop) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else if (wrap) begin
               count_d = '0;
               pd_d    = pd_inc;
               if (last) state_d = ST_DONE;
            end else begin
               count_d = count_q + CW'(1);
            end
`endif
         end
         ST_DONE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_ARM;
               pd_d    = '0;
            end
         end
         default: state_d = ST_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_OFF;
         count_q   <= '0;
         pd_q      <= '0;
         pend_q    <= 1'b0;
         loop_en_q <= 1'b0;
         loop_go_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef PULSE_SEQ_SOFT_STOP_EN
         stop_pend_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         pd_q      <= pd_d;
         pend_q    <= pend_d;
         loop_en_q <= (state_d != ST_OFF);
         loop_go_q <= (state_d == ST_ARM) || (state_d == ST_RUN);
         busy_q    <= (state_d == ST_ARM) || (state_d == ST_RUN);
         done_q    <= (state_d == ST_DONE);
`ifdef PULSE_SEQ_SOFT_STOP_EN
         stop_pend_q <= stop_pend_d;
`endif
      end
   end

   assign count        = count_q;
   assign periods_done = pd_q;
   assign period_strb  = wrap;
   assign swap_pend    = pend_q;
   assign loop_en      = loop_en_q;
   assign loop_go      = loop_go_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: doc/pulse_seq_ctrl.md
PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 20, number of pulse channels.
REQ-002 SHALL have parameter CW, default 32, counter/table width.
REQ-003 SHALL have parameter PW, default 16, period-count width.
REQ-004 SHALL have port clk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port cfg_we  in  1  write one shadow table entry.
REQ-007 SHALL have port cfg_ch  in  5  channel index of write.
REQ-008 SHALL have port cfg_beg / cfg_end  in  CW each  pulse begin/end counts for cfg_ch.
REQ-009 SHALL have port cfg_max_we / cfg_max  in  1 / CW  write shadow period length (inclusive max count).
REQ-010 SHALL have port commit  in  1  request shadow-to-active swap.
REQ-011 SHALL have ports start / stop  in  1 each  single-cycle commands.
REQ-012 SHALL have port n_periods  in  PW  periods to run; 0 = run forever.
REQ-013 SHALL have ports act_beg / act_end  out  N_CH x CW  active tables to the io loop.
REQ-014 SHALL have port act_max  out  CW  active max count.
REQ-015 SHALL have ports loop_en / loop_go  out  1 each  enable and run controls to the io loop.
REQ-016 SHALL have ports count  out  CW;  period_strb  out  1;  periods_done  out  PW.
REQ-017 SHALL have ports swap_pend, busy, done  out  1 each  status.

Function
REQ-018 SHALL implement FSM states OFF, IDLE, ARM, RUN, DONE.
REQ-019 OFF: loop_en=0, loop_go=0; leaves to IDLE on first cycle after rst deasserts.
REQ-020 IDLE: loop_en=1, loop_go=0, count=0; start -> ARM next cycle; periods_done cleared on start.
REQ-021 ARM: exactly one cycle, loop_en=1, loop_go=1, count=0 (io init cycle); -> RUN.
REQ-022 RUN: loop_en=1, loop_go=1; count increments by 1 per cycle; at count==act_max count wraps to 0, period_strb=1 that cycle, periods_done increments (saturating at all-ones).
REQ-023 At a wrap with n_periods!=0 and periods_done+1==n_periods -> DONE; count held 0.
REQ-024 DONE: loop_en=1, loop_go=0, done=1; start -> ARM (periods_done cleared); stop -> IDLE.
REQ-025 stop in ARM or RUN -> IDLE next cycle, count=0 (unless REQ-033 applies); start while ARM/RUN ignored; start and stop in the same cycle: stop wins.
REQ-026 busy=1 in ARM and RUN only.
REQ-027 cfg_we writes the shadow table any cycle; cfg_ch>=N_CH ignored; same-cycle cfg_we and swap: the swap copies the old shadow entry, the write lands in shadow.
REQ-028 commit in OFF/IDLE/DONE: active<=shadow next cycle; in ARM/RUN: swap_pend=1 and copy occurs on the wrap cycle, so the new table is valid when count=0.
REQ-029 commit while swap_pend=1 SHALL not queue a second swap; swap_pend clears in the swap cycle.
REQ-030 act_max=0: every RUN cycle is a wrap (period_strb held 1).

Reset
REQ-031 On rst: state OFF, count=0, periods_done=0, period_strb=0, swap_pend=0, done=0, busy=0, loop_en=0, loop_go=0, shadow and active tables and act_max=0; a rst mid-RUN SHALL take effect the next edge with no swap.

Configuration
REQ-032 Macro PULSE_SEQ_SOFT_STOP_EN selects stop behaviour.
REQ-033 Defined: stop in RUN sets a stop-pending flag; the FSM completes the current period, goes to IDLE on the wrap cycle (period counted, pending swap applied). Undefined: REQ-025 immediate stop.

Structure
REQ-034 Package pulse_seq_pkg SHALL hold the state enum, N_CH/CW/PW defaults and the channel index width.
REQ-035 Sub-module pulse_seq_bank SHALL hold the shadow/active double-buffered tables and the swap logic.

Verification
REQ-036 rst, start, act_max=3, n_periods=2 -> ARM 1 cycle, count 0,1,2,3,0,1,2,3, period_strb at both 3s, DONE with periods_done=2.
REQ-037 RUN act_max=9, commit at count=4 with shadow ch0 beg=2 -> swap_pend=1 until count wraps; act_beg[0]=2 from the count=0 cycle onward.
REQ-038 start+stop same cycle in IDLE -> stays IDLE; stop at count=5 (macro undefined) -> IDLE next cycle, count=0.
REQ-039 PULSE_SEQ_SOFT_STOP_EN defined, act_max=7, stop at count=2 -> RUN continues to 7, IDLE after wrap, periods_done+1.
REQ-040 rst asserted at count=6 with swap_pend=1 -> OFF next cycle, all outputs zero, no swap, IDLE one cycle after release.
